ex_pc_ctrl: RTL and testbench

- EX-side next-PC controller: the producer end of the pc_inc/next_pc interface that the fetch stage consumes.
- Each cycle it decides hold / sequential / redirect / halt for the PC flip-flop.
- Drives flush and stall to the IF/ID pipeline registers.
- Sequences multi-cycle mul/div stalls and post-redirect bubbles, and keeps stall/flush performance counters.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/sat_counter.sv | 19 +
 rtl/ex_pc_ctrl.sv | 159 +++++++++++++++
 tb/tb_ex_pc_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU control types: PC action codes used by fetch/pc_ff and the EX-side
// next-PC controller state encoding.
package cpu_pkg;

  typedef enum logic [1:0] {
    PC_HOLD = 2'b00,
    PC_SEQ  = 2'b01,
    PC_LOAD = 2'b10,
    PC_HALT = 2'b11
  } pc_inc_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    BUBBLE = 2'b01,
    MULDIV = 2'b10,
    HALT   = 2'b11
  } ctrl_state_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      count <= '0;
    end else if (inc && !(&count)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/ex_pc_ctrl.sv
// EX-side next-PC controller: decides hold/seq/redirect/halt, drives IF/ID flush and
// stall, sequences mul/div stalls and redirect bubbles, and counts stall/flush cycles.
module ex_pc_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned MULDIV_CYCLES    = 32,
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ex_valid,
  input  logic             jmp,
  input  logic [31:0]      jmp_target,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             muldiv_start,
  input  logic             syscall_halt,
  input  logic             hazard_stall,
  input  logic             if_halt,
  output pc_inc_t          pc_inc,
  output logic [31:0]      next_pc,
  output logic             flush,
  output logic             stall,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_cycles
);

  localparam logic [31:0] MdLoad = 32'(MULDIV_CYCLES - 1);
  localparam logic [31:0] RbLoad = 32'(REDIRECT_BUBBLES);

  ctrl_state_t state_q;
  logic [31:0] md_cnt_q;
  logic [31:0] bub_cnt_q;

  pc_inc_t     pc_act;
  logic [31:0] target;
  logic        flush_c;
  logic        stall_c;
  logic        go_halt;
  logic        redirect;
  logic        md_start;

  always_comb begin
    pc_act   = PC_SEQ;
    target   = 32'h0;
    flush_c  = 1'b0;
    stall_c  = 1'b0;
    go_halt  = 1'b0;
    redirect = 1'b0;
    md_start = 1'b0;
    unique case (state_q)
      RUN: begin
        if (if_halt || (ex_valid && syscall_halt)) begin
          pc_act  = PC_HALT;
          go_halt = 1'b1;
        end else if (ex_valid && (jmp || br_taken)) begin
          pc_act   = PC_LOAD;
          target   = jmp ? jmp_target : br_target;
          flush_c  = 1'b1;
          redirect = 1'b1;
        end else if (ex_valid && muldiv_start) begin
          pc_act   = PC_HOLD;
          stall_c  = 1'b1;
          md_start = 1'b1;
        end else if (hazard_stall) begin
          pc_act  = PC_HOLD;
          stall_c = 1'b1;
        end
      end
      BUBBLE: begin
        pc_act  = PC_HOLD;
        flush_c = 1'b1;
      end
      MULDIV: begin
        pc_act  = PC_HOLD;
        stall_c = 1'b1;
      end
      HALT: begin
        pc_act  = PC_HALT;
        stall_c = 1'b1;
      end
      default: ;
    endcase
    // Outputs read as the reset values for as long as clr is low.
    if (!clr) begin
      pc_act  = PC_SEQ;
      flush_c = 1'b0;
      stall_c = 1'b0;
    end
  end

  assign pc_inc  = pc_act;
  assign next_pc = (pc_act == PC_LOAD) ? align_word(target) : 32'h0;
  assign flush   = flush_c;
  assign stall   = stall_c;
  assign halted  = (state_q == HALT);

  // The issuing RUN cycle is the first of the MULDIV_CYCLES stall cycles.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= RUN;
      md_cnt_q  <= 32'h0;
      bub_cnt_q <= 32'h0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (go_halt) begin
            state_q <= HALT;
          end else if (redirect && (RbLoad != 32'h0)) begin
            state_q   <= BUBBLE;
            bub_cnt_q <= RbLoad;
          end else if (md_start && (MdLoad != 32'h0)) begin
            state_q  <= MULDIV;
            md_cnt_q <= MdLoad;
          end
        end
        BUBBLE: begin
          bub_cnt_q <= bub_cnt_q - 32'd1;
          if (if_halt) begin
            state_q <= HALT;
          end else if (bub_cnt_q <= 32'd1) begin
            state_q <= RUN;
          end
        end
        MULDIV: begin
          md_cnt_q <= md_cnt_q - 32'd1;
          if (if_halt) begin
            state_q <= HALT;
          end else if (md_cnt_q <= 32'd1) begin
            state_q <= RUN;
          end
        end
        HALT: state_q <= HALT;
        default: state_q <= RUN;
      endcase
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (clk),
    .clr  (clr),
    .inc  (stall_c && (state_q != HALT)),
    .count(stall_cycles)
  );

  sat_counter #(
    .W(CNT_W)
  ) u_flush_cnt (
    .clk  (clk),
    .clr  (clr),
    .inc  (flush_c),
    .count(flush_cycles)
  );

endmodule

// File: tb/tb_ex_pc_ctrl.sv
// Directed bench for ex_pc_ctrl: a per-cycle vector table plus hand-written sequences
// for halt, reset-in-flight and preemption cases.
module tb_ex_pc_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        ex_valid, jmp, br_taken, muldiv_start, syscall_halt, hazard_stall, if_halt;
  logic [31:0] jmp_target, br_target;
  logic [1:0]  pc_inc;
  logic [31:0] next_pc;
  logic        flush, stall, halted;
  logic [31:0] stall_cycles, flush_cycles;

  int n_checks = 0;
  int n_errors = 0;

  ex_pc_ctrl #(
    .MULDIV_CYCLES   (4),
    .REDIRECT_BUBBLES(1),
    .CNT_W           (32)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .ex_valid    (ex_valid),
    .jmp         (jmp),
    .jmp_target  (jmp_target),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .muldiv_start(muldiv_start),
    .syscall_halt(syscall_halt),
    .hazard_stall(hazard_stall),
    .if_halt     (if_halt),
    .pc_inc      (pc_inc),
    .next_pc     (next_pc),
    .flush       (flush),
    .stall       (stall),
    .halted      (halted),
    .stall_cycles(stall_cycles),
    .flush_cycles(flush_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ev, jp;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic        md, sys, haz, ifh;
    logic [1:0]  pc;
    logic [31:0] npc;
    logic        fl, st;
    logic [31:0] sc, fc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic ev, logic jp, logic [31:0] jt, logic br, logic [31:0] bt,
                              logic md, logic sys, logic haz, logic ifh, logic [1:0] pc,
                              logic [31:0] npc, logic fl, logic st, logic [31:0] sc,
                              logic [31:0] fc);
    vec_t v;
    v.ev = ev; v.jp = jp; v.jt = jt; v.br = br; v.bt = bt; v.md = md; v.sys = sys;
    v.haz = haz; v.ifh = ifh; v.pc = pc; v.npc = npc; v.fl = fl; v.st = st;
    v.sc = sc; v.fc = fc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic ev, input logic jp, input logic [31:0] jt, input logic br,
                       input logic [31:0] bt, input logic md, input logic sys, input logic haz,
                       input logic ifh);
    ex_valid = ev; jmp = jp; jmp_target = jt; br_taken = br; br_target = bt;
    muldiv_start = md; syscall_halt = sys; hazard_stall = haz; if_halt = ifh;
  endtask

  task automatic idle();
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " pc_inc"}, 32'(pc_inc), 32'h1);
    chk({tag, " next_pc"}, next_pc, 32'h0);
    chk({tag, " flush"}, 32'(flush), 32'h0);
    chk({tag, " stall"}, 32'(stall), 32'h0);
    chk({tag, " halted"}, 32'(halted), 32'h0);
    chk({tag, " stall_cycles"}, stall_cycles, 32'h0);
    chk({tag, " flush_cycles"}, flush_cycles, 32'h0);
  endtask

  task automatic do_reset();
    clr = 1'b0;
    #1;
    chk_reset_vals("reset");
    @(negedge clk);
    clr = 1'b1;
  endtask

  initial begin
    clr = 1'b0;
    drive(1, 1, 32'h100, 1, 32'h200, 1, 1, 1, 0);
    #2;
    chk_reset_vals("in_reset");
    @(negedge clk);
    clr = 1'b1;

    //            ev jp jt       br bt        md sy hz ih  pc    npc     fl st sc fc
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b01, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b01, 32'h0,   0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,       1, 32'h42,   0, 0, 0, 0, 2'b10, 32'h40,  1, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b00, 32'h0,   1, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b01, 32'h0,   0, 0, 0, 2));
    vecs.push_back(mk(1, 1, 32'h100, 1, 32'h200,  0, 0, 0, 0, 2'b10, 32'h100, 1, 0, 0, 2));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b00, 32'h0,   1, 0, 0, 3));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b01, 32'h0,   0, 0, 0, 4));
    vecs.push_back(mk(0, 1, 32'h300, 0, 0,        0, 1, 0, 0, 2'b01, 32'h0,   0, 0, 0, 4));
    vecs.push_back(mk(1, 0, 0,       0, 0,        1, 0, 0, 0, 2'b00, 32'h0,   0, 1, 0, 4));
    vecs.push_back(mk(1, 0, 0,       1, 32'h80,   0, 0, 0, 0, 2'b00, 32'h0,   0, 1, 1, 4));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b00, 32'h0,   0, 1, 2, 4));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b00, 32'h0,   0, 1, 3, 4));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b01, 32'h0,   0, 0, 4, 4));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 1, 0, 2'b00, 32'h0,   0, 1, 4, 4));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 1, 0, 2'b00, 32'h0,   0, 1, 5, 4));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 1, 0, 2'b00, 32'h0,   0, 1, 6, 4));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b01, 32'h0,   0, 0, 7, 4));
    vecs.push_back(mk(0, 0, 0,       0, 0,        0, 0, 1, 0, 2'b00, 32'h0,   0, 1, 7, 4));
    vecs.push_back(mk(1, 0, 0,       0, 0,        0, 0, 0, 0, 2'b01, 32'h0,   0, 0, 8, 4));

    foreach (vecs[i]) begin
      drive(vecs[i].ev, vecs[i].jp, vecs[i].jt, vecs[i].br, vecs[i].bt, vecs[i].md,
            vecs[i].sys, vecs[i].haz, vecs[i].ifh);
      #2;
      chk($sformatf("v%0d pc_inc", i), 32'(pc_inc), 32'(vecs[i].pc));
      chk($sformatf("v%0d next_pc", i), next_pc, vecs[i].npc);
      chk($sformatf("v%0d flush", i), 32'(flush), 32'(vecs[i].fl));
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(vecs[i].st));
      chk($sformatf("v%0d halted", i), 32'(halted), 32'h0);
      chk($sformatf("v%0d stall_cycles", i), stall_cycles, vecs[i].sc);
      chk($sformatf("v%0d flush_cycles", i), flush_cycles, vecs[i].fc);
      @(negedge clk);
    end

    // Halting syscall, then 100 absorbing cycles with unrelated activity on the inputs.
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0);
    #2;
    chk("halt_entry pc_inc", 32'(pc_inc), 32'h3);
    chk("halt_entry halted", 32'(halted), 32'h0);
    @(negedge clk);
    drive(1, 1, 32'h500, 0, 0, 1, 0, 1, 0);
    for (int c = 0; c < 100; c++) begin
      #2;
      chk($sformatf("halt c%0d pc_inc", c), 32'(pc_inc), 32'h3);
      chk($sformatf("halt c%0d halted", c), 32'(halted), 32'h1);
      chk($sformatf("halt c%0d stall", c), 32'(stall), 32'h1);
      @(negedge clk);
    end
    chk("halt stall_cycles", stall_cycles, 32'd8);
    chk("halt flush_cycles", flush_cycles, 32'd4);
    do_reset();

    // if_halt outranks a simultaneous jump.
    drive(1, 1, 32'h100, 0, 0, 0, 0, 0, 1);
    #2;
    chk("ifhalt_prio pc_inc", 32'(pc_inc), 32'h3);
    chk("ifhalt_prio flush", 32'(flush), 32'h0);
    chk("ifhalt_prio next_pc", next_pc, 32'h0);
    @(negedge clk);
    idle();
    #2;
    chk("ifhalt_prio halted", 32'(halted), 32'h1);
    do_reset();

    // if_halt during the redirect bubble goes straight to HALT.
    drive(1, 1, 32'h10, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("bubble_ifh flush", 32'(flush), 32'h1);
    @(negedge clk);
    idle();
    #2;
    chk("bubble_ifh halted", 32'(halted), 32'h1);
    chk("bubble_ifh pc_inc", 32'(pc_inc), 32'h3);
    do_reset();

    // Reset asserted between edges in the middle of a mul/div stall.
    drive(1, 0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    idle();
    #2;
    chk("mdreset pre stall", 32'(stall), 32'h1);
    chk("mdreset pre stall_cycles", stall_cycles, 32'd1);
    clr = 1'b0;
    #1;
    chk_reset_vals("mdreset");
    @(negedge clk);
    clr = 1'b1;
    #2;
    chk("mdreset post pc_inc", 32'(pc_inc), 32'h1);
    chk("mdreset post stall", 32'(stall), 32'h0);
    @(negedge clk);
    #2;
    chk("mdreset post2 pc_inc", 32'(pc_inc), 32'h1);
    chk("mdreset post2 stall", 32'(stall), 32'h0);
    chk("mdreset post2 stall_cycles", stall_cycles, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
